// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and default bus widths.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  localparam int AXI_ALEN = 32;
  localparam int AXI_DLEN = 32;

endpackage

// File: rtl/axi_lite_ram_bank.sv
// Single-port-pair RAM: byte-enabled write port, registered read-first read port.
module axi_lite_ram_bank #(
  parameter int DLEN  = 32,
  parameter int DEPTH = 1024,
  parameter int SLEN  = DLEN / 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [DLEN-1:0] wdata,
  input  logic [SLEN-1:0] wbe,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [DLEN-1:0] rdata
);

  logic [DLEN-1:0] mem [DEPTH];

  // Read and write in the same block: a same-word read sees the pre-write value.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we) begin
      for (int unsigned i = 0; i < SLEN; i++) begin
        if (wbe[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave backed by a word-organised RAM; one outstanding write and one read,
// SLVERR for word indices beyond DEPTH.
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int ALEN  = AXI_ALEN,
  parameter int DLEN  = AXI_DLEN,
  parameter int SLEN  = DLEN / 8,
  parameter int DEPTH = 1024
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            awvalid,
  output logic            awready,
  input  logic [ALEN-1:0] awaddr,
  input  logic [2:0]      awprot,
  input  logic            wvalid,
  output logic            wready,
  input  logic [DLEN-1:0] wdata,
  input  logic [SLEN-1:0] wstrb,
  output logic            bvalid,
  input  logic            bready,
  output logic [1:0]      bresp,
  input  logic            arvalid,
  output logic            arready,
  input  logic [ALEN-1:0] araddr,
  input  logic [2:0]      arprot,
  output logic            rvalid,
  input  logic            rready,
  output logic [DLEN-1:0] rdata,
  output logic [1:0]      rresp
);

  localparam int OFF  = $clog2(SLEN);
  localparam int IDXW = ALEN - OFF;
  localparam int AW   = $clog2(DEPTH);

  logic            aw_held, w_held;
  logic [ALEN-1:0] aw_addr_q;
  logic [DLEN-1:0] w_data_q;
  logic [SLEN-1:0] w_strb_q;
  resp_t           bresp_q, rresp_q;
  logic [DLEN-1:0] ram_rdata;

  logic [IDXW-1:0] wr_idx, rd_idx;
  logic            wr_ok, rd_ok, commit, ar_hs;

  assign wr_idx = aw_addr_q[ALEN-1:OFF];
  assign rd_idx = araddr[ALEN-1:OFF];
  assign wr_ok  = wr_idx < IDXW'(DEPTH);
  assign rd_ok  = rd_idx < IDXW'(DEPTH);

  // A commit waits for the previous B beat to drain, keeping one write past acceptance.
  assign commit = aw_held && w_held && !bvalid;
  assign ar_hs  = arvalid && !rvalid;

  assign awready = !aw_held;
  assign wready  = !w_held;
  assign arready = !rvalid;
  assign bresp   = bresp_q;
  assign rresp   = rresp_q;
  assign rdata   = (rvalid && rresp_q == OKAY) ? ram_rdata : '0;

  logic unused_bits;
  assign unused_bits = ^{awprot, arprot, awaddr[OFF-1:0], araddr[OFF-1:0]};

  axi_lite_ram_bank #(
    .DLEN  (DLEN),
    .DEPTH (DEPTH),
    .SLEN  (SLEN),
    .AW    (AW)
  ) u_ram (
    .clk   (aclk),
    .we    (commit && wr_ok),
    .waddr (wr_idx[AW-1:0]),
    .wdata (w_data_q),
    .wbe   (w_strb_q),
    .re    (ar_hs && rd_ok),
    .raddr (rd_idx[AW-1:0]),
    .rdata (ram_rdata)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid    <= 1'b0;
      bresp_q   <= OKAY;
      rvalid    <= 1'b0;
      rresp_q   <= OKAY;
    end else begin
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp_q <= wr_ok ? OKAY : SLVERR;
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end

      if (awvalid && !aw_held) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (wvalid && !w_held) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end

      if (ar_hs) begin
        rvalid  <= 1'b1;
        rresp_q <= rd_ok ? OKAY : SLVERR;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule
